// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and constants for the register-port arbiter and its debug reader.
package reg_port_arbiter_pkg;
   localparam int NUM_REGS_DEF    = 8;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int IDX_W           = 5;
   localparam int DATA_W          = 32;
   localparam int DBG_DATA_W      = 8;
   localparam int DBG_IDX_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } dbg_state_e;

   typedef enum logic {
      RR_A = 1'b0,
      RR_B = 1'b1
   } rr_e;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input int num_regs);
      return (int'(idx) >= num_regs - 1) ? '0 : idx + 1'b1;
   endfunction
endpackage

// File: rtl/reg_port_arbiter_if.sv
// Writeback requesters, pipeline read port, register-file ports and debug outputs.
interface reg_port_arbiter_if;
   import reg_port_arbiter_pkg::*;

   logic                  a_valid;
   logic [IDX_W-1:0]      a_rd;
   logic [DATA_W-1:0]     a_din;
   logic                  a_ready;
   logic                  b_valid;
   logic [IDX_W-1:0]      b_rd;
   logic [DATA_W-1:0]     b_din;
   logic                  b_ready;
   logic                  cpu_rd_en;
   logic [IDX_W-1:0]      cpu_rs;
   logic                  rf_writable;
   logic [IDX_W-1:0]      rf_rd;
   logic [DATA_W-1:0]     rf_din;
   logic [IDX_W-1:0]      rf_rs;
   logic [DATA_W-1:0]     rf_outa;
   logic                  dbg_valid;
   logic [DBG_DATA_W-1:0] dbg_data;
   logic [DBG_IDX_W-1:0]  dbg_index;

   modport slave (
      input  a_valid, a_rd, a_din, b_valid, b_rd, b_din, cpu_rd_en, cpu_rs, rf_outa,
      output a_ready, b_ready, rf_writable, rf_rd, rf_din, rf_rs,
             dbg_valid, dbg_data, dbg_index
   );

   modport master (
      output a_valid, a_rd, a_din, b_valid, b_rd, b_din, cpu_rd_en, cpu_rs, rf_outa,
      input  a_ready, b_ready, rf_writable, rf_rd, rf_din, rf_rs,
             dbg_valid, dbg_data, dbg_index
   );
endinterface

// File: rtl/reg_port_arbiter_push_sync.sv
// Synchronizes the asynchronous debug push button and flags its rising edge.
module reg_port_arbiter_push_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic push_i,
   output logic rise_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;

   // Shift in from the LSB; the MSB is the fully synchronized level.
   always_comb begin
      sync_d = SYNC_STAGES'({sync_q, push_i});
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbitration of two writeback ports onto one register-file write port,
// plus a push-button debug reader that steals idle cycles of read port A.
//
// state      | meaning
// ST_IDLE    | waiting for a pending debug step
// ST_ISSUE   | waiting for an idle pipeline read slot to drive rf_rs=idx
// ST_CAPTURE | rf_outa holds the debug register; latch its low byte
module reg_port_arbiter
   import reg_port_arbiter_pkg::*;
#(
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               push_i,
   reg_port_arbiter_if.slave  bus
);
   logic                  grant_a, grant_b, in_range, wr_en;
   logic [IDX_W-1:0]      sel_rd;
   logic [DATA_W-1:0]     sel_din;
   rr_e                   rr_q, rr_d;

   dbg_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic                  push_rise, cap_fire;
   logic [IDX_W-1:0]      rs_sel;
   logic                  dbg_valid_q, dbg_valid_d;
   logic [DBG_DATA_W-1:0] dbg_data_q, dbg_data_d;
   logic [DBG_IDX_W-1:0]  dbg_index_q, dbg_index_d;
   logic                  unused_bits;

   reg_port_arbiter_push_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_push_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push_i),
      .rise_o  (push_rise)
   );

   // Out-of-range destinations are still accepted so the requester is never stalled.
   always_comb begin
      grant_a  = bus.a_valid & (~bus.b_valid | (rr_q == RR_A));
      grant_b  = bus.b_valid & ~grant_a;
      sel_rd   = grant_a ? bus.a_rd  : bus.b_rd;
      sel_din  = grant_a ? bus.a_din : bus.b_din;
      in_range = (sel_rd != '0) && (int'(sel_rd) < NUM_REGS);
      wr_en    = (grant_a | grant_b) & in_range;
      rr_d     = rr_q;
      if (bus.a_valid & bus.b_valid) begin
         rr_d = grant_a ? RR_B : RR_A;
      end
   end

   assign bus.a_ready     = grant_a;
   assign bus.b_ready     = grant_b;
   assign bus.rf_writable = wr_en;
   assign bus.rf_rd       = wr_en ? sel_rd  : '0;
   assign bus.rf_din      = wr_en ? sel_din : '0;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pend_d   = pend_q;
      rs_sel   = bus.cpu_rs;
      cap_fire = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               state_d = ST_ISSUE;
               idx_d   = next_idx(idx_q, NUM_REGS);
            end
         end
         ST_ISSUE: begin
            if (!bus.cpu_rd_en) begin
               rs_sel  = idx_q;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            cap_fire = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A new edge wins over the clear so a push landing on the IDLE->ISSUE edge is kept.
      if (push_rise) begin
         pend_d = 1'b1;
      end else if ((state_q == ST_IDLE) && pend_q) begin
         pend_d = 1'b0;
      end
      dbg_valid_d = cap_fire;
      dbg_data_d  = cap_fire ? bus.rf_outa[DBG_DATA_W-1:0] : dbg_data_q;
      dbg_index_d = cap_fire ? idx_q[DBG_IDX_W-1:0] : dbg_index_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_q        <= RR_A;
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         dbg_valid_q <= 1'b0;
         dbg_data_q  <= '0;
         dbg_index_q <= '0;
      end else begin
         rr_q        <= rr_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         dbg_valid_q <= dbg_valid_d;
         dbg_data_q  <= dbg_data_d;
         dbg_index_q <= dbg_index_d;
      end
   end

   assign bus.rf_rs     = rs_sel;
   assign bus.dbg_valid = dbg_valid_q;
   assign bus.dbg_data  = dbg_data_q;
   assign bus.dbg_index = dbg_index_q;

   // Only the low byte of read data and the low index bits reach the debug outputs.
   assign unused_bits = ^{bus.rf_outa[DATA_W-1:DBG_DATA_W], idx_q[IDX_W-1:DBG_IDX_W]};
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioral register file on the ports.
module tb_reg_port_arbiter;
   logic clk;
   logic rst_n;
   logic push;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] rf_mem [32] = '{default: 32'h0};
   logic [7:0]  exp_b;
   logic        found;

   reg_port_arbiter_if ifc ();

   reg_port_arbiter #(
      .NUM_REGS    (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .push_i  (push),
      .bus     (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: synchronous write, read data one cycle after rf_rs.
   always @(posedge clk) begin
      if (ifc.rf_writable) rf_mem[ifc.rf_rd] <= ifc.rf_din;
      ifc.rf_outa <= rf_mem[ifc.rf_rs];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_push();
      push = 1'b1;
      repeat (3) @(negedge clk);
      push = 1'b0;
   endtask

   task automatic wait_rs(input string tag, input logic [4:0] target);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (ifc.rf_rs == target) found = 1'b1;
      end
      chk(tag, {31'b0, found}, 32'd1);
   endtask

   task automatic wait_dbg(input string tag);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (ifc.dbg_valid) found = 1'b1;
      end
      chk(tag, {31'b0, found}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      push  = 1'b0;
      ifc.a_valid = 1'b0; ifc.a_rd = '0; ifc.a_din = '0;
      ifc.b_valid = 1'b0; ifc.b_rd = '0; ifc.b_din = '0;
      ifc.cpu_rd_en = 1'b0; ifc.cpu_rs = '0;
      repeat (2) @(negedge clk);
      chk("rst_dbg_valid", {31'b0, ifc.dbg_valid}, 32'd0);
      chk("rst_dbg_data",  {24'b0, ifc.dbg_data}, 32'd0);
      chk("rst_dbg_index", {28'b0, ifc.dbg_index}, 32'd0);
      chk("idle_rf_rd",    {27'b0, ifc.rf_rd}, 32'd0);
      chk("idle_rf_din",   ifc.rf_din, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_no_write", {31'b0, ifc.rf_writable}, 32'd0);

      // Single requester A
      @(negedge clk);
      ifc.a_valid = 1'b1; ifc.a_rd = 5'd3; ifc.a_din = 32'h55;
      #1;
      chk("a_only_ready", {31'b0, ifc.a_ready}, 32'd1);
      chk("a_only_wr",    {31'b0, ifc.rf_writable}, 32'd1);
      chk("a_only_rd",    {27'b0, ifc.rf_rd}, 32'd3);
      chk("a_only_din",   ifc.rf_din, 32'h55);

      // Contention: A, then B, idle, then A again
      @(negedge clk);
      ifc.a_rd = 5'd2; ifc.a_din = 32'hAA;
      ifc.b_valid = 1'b1; ifc.b_rd = 5'd4; ifc.b_din = 32'hBB;
      #1;
      chk("rr1_a_ready", {31'b0, ifc.a_ready}, 32'd1);
      chk("rr1_b_ready", {31'b0, ifc.b_ready}, 32'd0);
      chk("rr1_rf_rd",   {27'b0, ifc.rf_rd}, 32'd2);
      @(negedge clk);
      #1;
      chk("rr2_a_ready", {31'b0, ifc.a_ready}, 32'd0);
      chk("rr2_b_ready", {31'b0, ifc.b_ready}, 32'd1);
      chk("rr2_rf_rd",   {27'b0, ifc.rf_rd}, 32'd4);
      chk("rr2_rf_din",  ifc.rf_din, 32'hBB);
      @(negedge clk);
      ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
      #1;
      chk("none_wr",  {31'b0, ifc.rf_writable}, 32'd0);
      chk("none_din", ifc.rf_din, 32'd0);
      @(negedge clk);
      ifc.a_valid = 1'b1; ifc.a_rd = 5'd5; ifc.a_din = 32'h5;
      ifc.b_valid = 1'b1; ifc.b_rd = 5'd6; ifc.b_din = 32'h6;
      #1;
      chk("rr3_a_ready", {31'b0, ifc.a_ready}, 32'd1);
      chk("rr3_b_ready", {31'b0, ifc.b_ready}, 32'd0);

      // Out-of-range destinations accepted without writing
      @(negedge clk);
      ifc.a_valid = 1'b0; ifc.b_rd = 5'd0; ifc.b_din = 32'hDEAD;
      #1;
      chk("rd0_ready", {31'b0, ifc.b_ready}, 32'd1);
      chk("rd0_wr",    {31'b0, ifc.rf_writable}, 32'd0);
      @(negedge clk);
      ifc.b_rd = 5'd8;
      #1;
      chk("rd8_ready", {31'b0, ifc.b_ready}, 32'd1);
      chk("rd8_wr",    {31'b0, ifc.rf_writable}, 32'd0);
      @(negedge clk);
      ifc.b_rd = 5'd7; ifc.b_din = 32'h770;
      #1;
      chk("rd7_wr", {31'b0, ifc.rf_writable}, 32'd1);

      // Preload reg1=0x1A7 and regs 2..7 with low byte i<<4
      @(negedge clk);
      ifc.b_valid = 1'b0;
      ifc.a_valid = 1'b1; ifc.a_rd = 5'd1; ifc.a_din = 32'h1A7;
      for (int i = 2; i < 8; i++) begin
         @(negedge clk);
         ifc.a_rd = 5'(i); ifc.a_din = 32'h200 | (32'(i) << 4);
      end
      @(negedge clk);
      ifc.a_valid = 1'b0;

      // Debug read of reg1 with an idle read port
      pulse_push();
      wait_rs("dbg1_issue_rs", 5'd1);
      @(negedge clk);
      chk("dbg1_capture_no_valid", {31'b0, ifc.dbg_valid}, 32'd0);
      @(negedge clk);
      chk("dbg1_valid", {31'b0, ifc.dbg_valid}, 32'd1);
      chk("dbg1_data",  {24'b0, ifc.dbg_data}, 32'hA7);
      chk("dbg1_index", {28'b0, ifc.dbg_index}, 32'd1);
      @(negedge clk);
      chk("dbg1_pulse_end", {31'b0, ifc.dbg_valid}, 32'd0);

      // Pipeline keeps the read port for 5 cycles while the step is pending
      ifc.cpu_rd_en = 1'b1; ifc.cpu_rs = 5'd9;
      pulse_push();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ifc.cpu_rs = 5'(10 + i);
         #1;
         chk("busy_rf_rs", {27'b0, ifc.rf_rs}, 32'(10 + i));
         chk("busy_no_valid", {31'b0, ifc.dbg_valid}, 32'd0);
      end
      @(negedge clk);
      ifc.cpu_rd_en = 1'b0; ifc.cpu_rs = 5'd0;
      #1;
      chk("steal_rf_rs", {27'b0, ifc.rf_rs}, 32'd2);
      @(negedge clk);
      chk("steal_capture_no_valid", {31'b0, ifc.dbg_valid}, 32'd0);
      @(negedge clk);
      chk("steal_valid", {31'b0, ifc.dbg_valid}, 32'd1);
      chk("steal_index", {28'b0, ifc.dbg_index}, 32'd2);
      chk("steal_data",  {24'b0, ifc.dbg_data}, 32'h20);

      // Fresh reset, then 8 steps wrap the index 1..7, 0
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         pulse_push();
         wait_dbg("wrap_seen");
         exp_b = (k == 8) ? 8'h00 : (k == 1) ? 8'hA7 : 8'(k << 4);
         chk("wrap_index", {28'b0, ifc.dbg_index}, 32'(k % 8));
         chk("wrap_data",  {24'b0, ifc.dbg_data}, {24'b0, exp_b});
      end

      // Reset during CAPTURE aborts the read
      pulse_push();
      wait_rs("abort_issue_rs", 5'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_dbg_valid", {31'b0, ifc.dbg_valid}, 32'd0);
      chk("abort_dbg_index", {28'b0, ifc.dbg_index}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_pulse", {31'b0, ifc.dbg_valid}, 32'd0);
      end
      pulse_push();
      wait_dbg("after_abort_seen");
      chk("after_abort_index", {28'b0, ifc.dbg_index}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
